// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp32_pkg
// Brief    : Shared FP32 constants and the reduction sequencer state encoding.
// Revision : 1.0
// ============================================================================
package fp32_pkg;

    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_IN  = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_ADD = 3'd3,
        ST_DONE     = 3'd4
    } reduce_state_t;

endpackage
`default_nettype wire

// File: rtl/fp32_reduce_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp32_reduce_seq
// Brief    : Folds a stream of FP32 values into one sum through an external
//            two-operand adder, one add in flight at a time.
// Revision : 1.0
// ============================================================================
module fp32_reduce_seq
    import fp32_pkg::*;
#(
    parameter int MAX_LEN     = 256,
    parameter int CNT_W       = $clog2(MAX_LEN + 1),
    parameter int ADD_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_valid,
    input  logic [31:0]      add_result,
    input  logic             add_valid_out
);

    localparam int              TMO_W      = $clog2(ADD_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(ADD_TIMEOUT - 1);

    reduce_state_t    r_state, w_state_nxt;
    logic [31:0]      r_acc, w_acc_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_len, w_len_nxt;
    logic             r_err, w_err_nxt;
    logic [31:0]      r_add_a, w_add_a_nxt;
    logic [31:0]      r_add_b, w_add_b_nxt;
    logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= FP32_POS_ZERO;
            r_cnt   <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
            r_add_a <= '0;
            r_add_b <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_err   <= w_err_nxt;
            r_add_a <= w_add_a_nxt;
            r_add_b <= w_add_b_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_err_nxt   = r_err;
        w_add_a_nxt = r_add_a;
        w_add_b_nxt = r_add_b;
        w_tmo_nxt   = r_tmo;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_err_nxt = 1'b0;
                    w_cnt_nxt = '0;
                    w_len_nxt = len;
                    if (len == '0) begin
                        w_acc_nxt   = FP32_POS_ZERO;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_WAIT_IN;
                    end
                end
            end
            ST_WAIT_IN: begin
                if (in_valid) begin
                    if (r_cnt == '0) begin
                        // First element is taken verbatim so a lone -0.0 survives.
                        w_acc_nxt = in_data;
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == r_len) w_state_nxt = ST_DONE;
                    end else begin
                        w_add_a_nxt = r_acc;
                        w_add_b_nxt = in_data;
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                w_tmo_nxt   = '0;
                w_state_nxt = ST_WAIT_ADD;
            end
            ST_WAIT_ADD: begin
                if (add_valid_out) begin
                    w_acc_nxt   = add_result;
                    w_cnt_nxt   = w_cnt_inc;
                    w_state_nxt = (w_cnt_inc == r_len) ? ST_DONE : ST_WAIT_IN;
                end else if (r_tmo == c_tmo_last) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Every output is a register or a decode of the state register.
    assign in_ready  = (r_state == ST_WAIT_IN);
    assign add_valid = (r_state == ST_ISSUE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_sum   = r_acc;
    assign err       = r_err;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;

endmodule
`default_nettype wire

// File: tb/tb_fp32_reduce_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_reduce_seq
// Brief    : Directed self-checking bench with a two-stage table-driven adder.
// Revision : 1.0
// ============================================================================
module tb_fp32_reduce_seq;

    localparam int CNT_W       = 9;
    localparam int ADD_TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic [31:0]      in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      out_sum;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             err;
    logic [31:0]      add_a, add_b;
    logic             add_valid;
    logic [31:0]      add_result;
    logic             add_valid_out;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int in_ready_seen = 0;
    logic stub_dead = 1'b0;

    fp32_reduce_seq #(.MAX_LEN(256), .CNT_W(CNT_W), .ADD_TIMEOUT(ADD_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_sum(out_sum), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err(err), .add_a(add_a), .add_b(add_b),
        .add_valid(add_valid), .add_result(add_result), .add_valid_out(add_valid_out)
    );

    always #5 clk = ~clk;

    // Adder stand-in: known sums only, two register stages, not reset so a
    // response to an add issued before rst still arrives afterwards.
    function automatic logic [31:0] addf(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: addf = 32'h40400000;
            {32'h40400000, 32'h40400000}: addf = 32'h40C00000;
            {32'h40C00000, 32'h40800000}: addf = 32'h41200000;
            {32'h3F800000, 32'h7F800000}: addf = 32'h7F800000;
            {32'h7F800000, 32'h3F800000}: addf = 32'h7F800000;
            {32'h7FC00000, 32'h3F800000}: addf = 32'h7FC00000;
            {32'h3F800000, 32'h3F800000}: addf = 32'h40000000;
            {32'h40000000, 32'h3F800000}: addf = 32'h40400000;
            {32'h40000000, 32'h40000000}: addf = 32'h40800000;
            default:                      addf = 32'hDEADBEEF;
        endcase
    endfunction

    logic        s1_v = 1'b0, s2_v = 1'b0;
    logic [31:0] s1_r = '0, s2_r = '0;
    always @(posedge clk) begin
        s1_v <= add_valid;
        s1_r <= addf(add_a, add_b);
        s2_v <= s1_v & ~stub_dead;
        s2_r <= s1_r;
    end
    assign add_valid_out = s2_v;
    assign add_result    = s2_r;

    always @(negedge clk) begin
        if (add_valid === 1'b1) pulses++;
        if (in_ready === 1'b1)  in_ready_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int l);
        start = 1'b1;
        len   = CNT_W'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_elem(input logic [31:0] d, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [31:0] exp, input logic exp_err, input int hold);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_sum"}, out_sum, exp);
        check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_sum"}, out_sum, exp);
            check({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle"}, {30'b0, busy, out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_outs", {26'b0, in_ready, out_valid, busy, err, add_valid, 1'b0}, 32'd0);
        check("rst_sum", out_sum, 32'h0);
        check("rst_add_a", add_a, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // len=4: 1+2+3+4 = 10
        pulses = 0;
        start_run(4);
        send_elem(32'h3F800000, 0);
        send_elem(32'h40000000, 0);
        send_elem(32'h40400000, 0);
        send_elem(32'h40800000, 0);
        wait_out("sum4", 32'h41200000, 1'b0, 0);
        check("sum4_pulses", pulses, 32'd3);

        // len=1: -1.0 and -0.0 pass through with no add
        pulses = 0;
        start_run(1);
        send_elem(32'hBF800000, 0);
        wait_out("one_neg", 32'hBF800000, 1'b0, 0);
        start_run(1);
        send_elem(32'h80000000, 0);
        wait_out("one_nzero", 32'h80000000, 1'b0, 0);
        check("one_pulses", pulses, 32'd0);

        // len=0: result the very next cycle, no element request
        in_ready_seen = 0;
        start_run(0);
        check("len0_valid", {31'b0, out_valid}, 32'd1);
        wait_out("len0", 32'h0, 1'b0, 0);
        check("len0_in_ready", in_ready_seen, 32'd0);

        // Inf and NaN propagate
        start_run(3);
        send_elem(32'h3F800000, 0);
        send_elem(32'h7F800000, 0);
        send_elem(32'h3F800000, 0);
        wait_out("inf", 32'h7F800000, 1'b0, 0);
        start_run(2);
        send_elem(32'h7FC00000, 0);
        send_elem(32'h3F800000, 0);
        wait_out("nan", 32'h7FC00000, 1'b0, 0);

        // Gapped input, stray start while busy, held output
        start_run(3);
        send_elem(32'h3F800000, 2);
        start = 1'b1;
        len   = CNT_W'(1);
        @(negedge clk);
        start = 1'b0;
        send_elem(32'h3F800000, 0);
        send_elem(32'h3F800000, 3);
        wait_out("bp", 32'h40400000, 1'b0, 5);
        @(negedge clk);
        check("bp_stray_start", {31'b0, busy}, 32'd0);

        // Reset in the middle of an add; its late response must be dropped
        start_run(4);
        send_elem(32'h3F800000, 0);
        send_elem(32'h40000000, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_outs", {26'b0, in_ready, out_valid, busy, err, add_valid, 1'b0}, 32'd0);
        check("mid_rst_sum", out_sum, 32'h0);
        check("mid_rst_add", add_a | add_b, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("late_resp", {30'b0, busy, out_valid}, 32'd0);
        check("late_resp_sum", out_sum, 32'h0);
        start_run(2);
        send_elem(32'h40000000, 0);
        send_elem(32'h40000000, 0);
        wait_out("after_rst", 32'h40800000, 1'b0, 0);

        // Silent adder: timeout after ADD_TIMEOUT cycles in WAIT_ADD
        stub_dead = 1'b1;
        start_run(2);
        send_elem(32'h3F800000, 0);
        send_elem(32'h40000000, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tmo_latency", n, ADD_TIMEOUT + 1);
        wait_out("tmo", 32'h3F800000, 1'b1, 0);
        check("tmo_sticky", {31'b0, err}, 32'd1);
        stub_dead = 1'b0;
        repeat (4) @(negedge clk);
        start_run(0);
        check("err_clear", {31'b0, err}, 32'd0);
        wait_out("err_clear_run", 32'h0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
